alu_encoder: RTL
================

ALU_ENCODER -- requirements
Module: alu_encoder

Interface
REQ-001 The module SHALL have one clock and one reset: clk input 1, rising-edge clock; rst input 1, asynchronous active-high reset.
REQ-002 The module SHALL have these request ports:
- req_valid, input, 1 bit.
- req_ready, output, 1 bit: request accepted when high together with req_valid at a clk edge.
- req_op, input, 4 bits: ALU code. 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 LUI.
REQ-003 The module SHALL have these operand ports:
- req_rd, input, 5 bits.
- req_rs1, input, 5 bits.
- req_rs2, input, 5 bits.
- req_imm, input, 20 bits.
- req_imm_sel, input, 1 bit: immediate form.
- req_branch, input, 1 bit: branch form.
- req_br_neg, input, 1 bit: negated branch condition.
REQ-004 The module SHALL have these output ports:
- instr_valid, output, 1 bit.
- instr_ready, input, 1 bit.
- instr, output, 32 bits: encoded RV32I word.
- err, output, 1 bit: one-cycle pulse.
- err_count, output, 8 bits.

Function
REQ-005 Each accepted legal request SHALL be encoded and pushed into a 4-entry FIFO in the acceptance cycle.
REQ-006 req_ready SHALL be high exactly when FIFO count < 4; a pop in the same cycle SHALL NOT raise req_ready while full.
REQ-007 instr_valid SHALL equal (count != 0); instr SHALL be the FIFO head, or 0 when empty.
REQ-008 Pop SHALL occur on instr_valid && instr_ready; simultaneous push and pop SHALL leave count unchanged.
REQ-009 Latency: a request accepted at edge N into an empty FIFO SHALL show instr_valid high after edge N.
REQ-010 Pointers SHALL be 2-bit and wrap modulo 4.
REQ-011 R-type (req_branch=0, req_imm_sel=0, op 0-9) SHALL encode as follows:
- opcode 0110011.
- funct3: ADD/SUB 000, SLL 001, SLT 010, SLTU 011, XOR 100, SRL/SRA 101, OR 110, AND 111.
- funct7: 0100000 for SUB and SRA, otherwise 0000000.
REQ-012 I-type (req_imm_sel=1, op 0,2-9) SHALL encode as follows:
- opcode 0010011, with the same funct3 as R-type.
- [31:20] = req_imm[11:0].
- For SLL/SRL/SRA: [24:20] = req_imm[4:0] and [31:25] = funct7 per REQ-011.
REQ-013 LUI (op 10, req_branch=0) SHALL encode as opcode 0110111, [31:12] = req_imm, [11:7] = rd; req_imm_sel SHALL be ignored.
REQ-014 Illegal requests SHALL be accepted but not pushed. They are:
- SUB with req_imm_sel=1.
- op 11-15.
- Branch forms disallowed by REQ-017.
REQ-015 For an illegal request, err SHALL pulse high for one cycle after the accept edge, and err_count SHALL increment, saturating at 255.
REQ-016 Unused fields SHALL be encoded as 0 (e.g. rd for branches, rs2 for I/U-type).

Reset
REQ-018 While rst is high the following SHALL hold, asynchronously:
- count = 0 and pointers = 0.
- instr_valid = 0 and instr = 0.
- err = 0 and err_count = 0.
- req_ready = 1 once rst is low.
REQ-019 Reset mid-operation SHALL discard all FIFO contents; no partial word SHALL appear after release.

Configuration
REQ-017 When macro ALU_ENCODER_BRANCH_EN is defined, req_branch=1 SHALL encode a B-type instruction:
- opcode 1100011.
- SUB maps to BEQ (000) or BNE (001).
- SLT maps to BLT (100) or BGE (101).
- SLTU maps to BLTU (110) or BGEU (111).
- The second of each pair is selected by req_br_neg=1.
- Offset = req_imm[12:1], placed as [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11]; req_imm[0] ignored.
- Other ops with req_branch=1 are illegal.
REQ-020 Without ALU_ENCODER_BRANCH_EN, every request with req_branch=1 SHALL be illegal per REQ-014/015, and no B-type logic SHALL be synthesized.

Verification
REQ-021 ADD, rd=3, rs1=1, rs2=2, imm_sel=0 -> instr 0x002081B3 one cycle after accept.
REQ-022 Back-to-back SUB(rd5, rs1 6, rs2 7), ADDI(rd1, rs1 0, imm 0xFFF), SRAI(rd2, rs1 2, imm 3), LUI(rd10, imm 0x12345) with instr_ready=1 -> 0x407302B3, 0xFFF00093, 0x40315113, 0x12345537 in order.
REQ-023 instr_ready=0 with 5 pushes -> req_ready low after 4th accept; 5th request held; raising instr_ready for 1 cycle lets the 5th be accepted the next cycle; order preserved across pointer wrap.
REQ-024 op=12, then SUB with imm_sel=1 -> two err pulses, err_count=2, FIFO count unchanged; 300 illegal requests -> err_count=255.
REQ-025 With ALU_ENCODER_BRANCH_EN: branch SUB, rs1=1, rs2=2, imm=8, br_neg=0 -> 0x00208463. Without the macro the same request -> err pulse, no word.
REQ-026 rst asserted asynchronously with 3 entries queued -> instr_valid=0 and err_count=0 immediately; after release the first new request's word is the only one output.

Source files
------------

// File: rtl/alu_encoder.sv
// RV32I ALU-instruction encoder feeding a 4-entry output FIFO; illegal requests raise err.
// Define ALU_ENCODER_BRANCH_EN to also encode req_branch=1 requests as B-type compares.
module alu_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [4:0]  req_rd,
  input  logic [4:0]  req_rs1,
  input  logic [4:0]  req_rs2,
  input  logic [19:0] req_imm,
  input  logic        req_imm_sel,
  input  logic        req_branch,
  input  logic        req_br_neg,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic        err,
  output logic [7:0]  err_count
);

  localparam logic [3:0] OP_SUB = 4'd1, OP_SLL = 4'd2, OP_SLT = 4'd3, OP_SLTU = 4'd4;
  localparam logic [3:0] OP_SRL = 4'd6, OP_SRA = 4'd7, OP_LUI = 4'd10;

  logic [2:0]       count_q, count_d;
  logic [1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [3:0][31:0] mem_q, mem_d;
  logic             err_q, err_d;
  logic [7:0]       err_count_q, err_count_d;

  logic        legal;
  logic [31:0] word;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        is_shift;
  logic        accept, push, pop;

  always_comb begin
    unique case (req_op)
      4'd2:       f3 = 3'b001;
      4'd3:       f3 = 3'b010;
      4'd4:       f3 = 3'b011;
      4'd5:       f3 = 3'b100;
      4'd6, 4'd7: f3 = 3'b101;
      4'd8:       f3 = 3'b110;
      4'd9:       f3 = 3'b111;
      default:    f3 = 3'b000;
    endcase
    f7       = (req_op == OP_SUB || req_op == OP_SRA) ? 7'b0100000 : 7'b0000000;
    is_shift = (req_op == OP_SLL || req_op == OP_SRL || req_op == OP_SRA);
  end

`ifdef ALU_ENCODER_BRANCH_EN
  logic [2:0] bf3;
  logic       br_ok;
  always_comb begin
    br_ok = 1'b1;
    bf3   = 3'b000;
    unique case (req_op)
      OP_SUB:  bf3 = {2'b00, req_br_neg};
      OP_SLT:  bf3 = {2'b10, req_br_neg};
      OP_SLTU: bf3 = {2'b11, req_br_neg};
      default: br_ok = 1'b0;
    endcase
  end
`else
  // Branch inputs are don't-care when branches are compiled out.
  logic unused_br;
  assign unused_br = req_br_neg;
`endif

  always_comb begin
    legal = 1'b1;
    word  = 32'h0;
    if (req_branch) begin
`ifdef ALU_ENCODER_BRANCH_EN
      legal = br_ok;
      if (br_ok)
        word = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, bf3,
                req_imm[4:1], req_imm[11], 7'b1100011};
`else
      legal = 1'b0;
`endif
    end else if (req_op == OP_LUI) begin
      word = {req_imm, req_rd, 7'b0110111};
    end else if (req_op > OP_LUI) begin
      legal = 1'b0;
    end else if (req_imm_sel) begin
      if (req_op == OP_SUB)
        legal = 1'b0;
      else if (is_shift)
        word = {f7, req_imm[4:0], req_rs1, f3, req_rd, 7'b0010011};
      else
        word = {req_imm[11:0], req_rs1, f3, req_rd, 7'b0010011};
    end else begin
      word = {f7, req_rs2, req_rs1, f3, req_rd, 7'b0110011};
    end
  end

  assign req_ready   = ~count_q[2];
  assign instr_valid = (count_q != 3'd0);
  assign instr       = instr_valid ? mem_q[rd_ptr_q] : 32'h0;
  assign err         = err_q;
  assign err_count   = err_count_q;

  assign accept = req_valid & req_ready;
  assign push   = accept & legal;
  assign pop    = instr_valid & instr_ready;

  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    err_d       = accept & ~legal;
    err_count_d = err_count_q;
    if (push) begin
      mem_d[wr_ptr_q] = word;
      wr_ptr_d        = wr_ptr_q + 2'd1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 2'd1;
    if (push && !pop)      count_d = count_q + 3'd1;
    else if (pop && !push) count_d = count_q - 3'd1;
    if (err_d && err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q       <= '0;
      wr_ptr_q    <= 2'd0;
      rd_ptr_q    <= 2'd0;
      count_q     <= 3'd0;
      err_q       <= 1'b0;
      err_count_q <= 8'd0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      err_q       <= err_d;
      err_count_q <= err_count_d;
    end
  end

endmodule
